// File: rtl/risc_pkg.sv
// Shared encodings for the 8-bit RISC datapath data-memory responder.
package risc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // A simultaneous read+write request is taken as a write; the read is dropped.
  function automatic logic decode_op(input logic en_wr);
    return en_wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Synchronous single-port RAM, read-before-write; kept separate so a vendor macro can drop in.
module dm_array #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one en_DM_rd/en_DM_wr request, waits WAIT_STATES
// cycles, then answers with a one-cycle rd_valid or wr_ack pulse.
module data_mem_resp
  import risc_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_DM_rd,
  input  logic          en_DM_wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          wr_ack,
  output logic          busy
);

  localparam logic [3:0] CNT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wr_data_q;
  logic [DW-1:0] rd_hold;

  logic          req;
  logic          accept;
  logic          enter_resp;
  logic          op_cur;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  assign req    = en_DM_rd | en_DM_wr;
  assign accept = (state == ST_IDLE) && req;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == CNT_LAST) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the RAM must see the live request rather than the latched copy.
  assign op_cur   = (state == ST_IDLE) ? decode_op(en_DM_wr) : op_q;
  assign ram_addr = (state == ST_IDLE) ? addr    : addr_q;
  assign ram_din  = (state == ST_IDLE) ? wr_data : wr_data_q;
  assign ram_we   = enter_resp && (op_cur == OP_WR);

  dm_array #(
    .DW(DW),
    .AW(AW)
  ) u_array (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      op_q  <= OP_RD;
    end else begin
      state <= state_nxt;
      if ((state == ST_WAIT) && (state_nxt == ST_WAIT)) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
      if (accept) begin
        op_q <= decode_op(en_DM_wr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q    <= addr;
      wr_data_q <= wr_data;
    end
  end

  // rd_data follows the RAM during the response and then holds that value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hold <= '0;
    end else if (rd_valid) begin
      rd_hold <= ram_dout;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign rd_valid = (state == ST_RESP) && (op_q == OP_RD);
  assign wr_ack   = (state == ST_RESP) && (op_q == OP_WR);
  assign rd_data  = rd_valid ? ram_dout : rd_hold;

endmodule
